// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax streamer TCDM responder.
package sfm_pkg;

   localparam int unsigned SFM_TCDM_DW        = 128;
   localparam logic [31:0] SFM_TCDM_POISON    = 32'hDEADBEEF;
   localparam logic [15:0] SFM_TCDM_LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic [SFM_TCDM_DW-1:0] data;
      logic                   user;
   } sfm_tcdm_resp_t;

   // Index width that stays at least one bit wide for single-entry structures.
   function automatic int unsigned sfm_clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sfm_tcdm_resp_pipe.sv
// Fixed-latency shift pipe carrying TCDM responses from grant to the response FIFO.
module sfm_tcdm_resp_pipe #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned WIDTH   = 129
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic [LATENCY-1:0] stage_valid;
   logic [WIDTH-1:0]   stage_data [LATENCY];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) stage_data[i] <= '0;
      end else if (clear_i) begin
         stage_valid <= '0;
      end else begin
         stage_valid[0] <= valid_i;
         stage_data[0]  <= data_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_data[i]  <= stage_data[i-1];
         end
      end
   end

   assign valid_o = stage_valid[LATENCY-1];
   assign data_o  = stage_data[LATENCY-1];

endmodule

// File: rtl/sfm_tcdm_responder.sv
// TCDM scratchpad responder: fixed-latency responses for every grant, tcdm_* are the hci_core slave signals.
// Optional grant stalling via an LFSR when SFM_TCDM_RESP_STALL_EN is defined.
module sfm_tcdm_responder
   import sfm_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = SFM_TCDM_DW,
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           MEM_DEPTH    = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int unsigned           READ_LATENCY = 2,
   parameter int unsigned           OUTSTANDING  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    tcdm_req,
   output logic                    tcdm_gnt,
   input  logic [ADDR_WIDTH-1:0]   tcdm_add,
   input  logic                    tcdm_wen,
   input  logic [DATA_WIDTH/8-1:0] tcdm_be,
   input  logic [DATA_WIDTH-1:0]   tcdm_data,
   input  logic                    tcdm_user,
   input  logic                    tcdm_r_ready,
   output logic                    tcdm_r_valid,
   output logic [DATA_WIDTH-1:0]   tcdm_r_data,
   output logic                    tcdm_r_user,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam int unsigned BE_W   = DATA_WIDTH / 8;
   localparam int unsigned OFFS   = $clog2(BE_W);
   localparam int unsigned IDX_W  = sfm_clog2_min1(MEM_DEPTH);
   localparam int unsigned PTR_W  = sfm_clog2_min1(OUTSTANDING);
   localparam int unsigned CNT_W  = $clog2(OUTSTANDING + 1);
   localparam int unsigned RESP_W = DATA_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BE_W);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  user;
   } resp_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_range;
   logic [IDX_W-1:0]      word_idx;
   logic [CNT_W-1:0]      outstanding;
   logic                  stall_ok;
   logic                  err_q;
   resp_t                 grant_resp;
   logic                  pipe_valid;
   logic [RESP_W-1:0]     pipe_data;
   resp_t                 pipe_resp;
   resp_t                 fifo_mem [OUTSTANDING];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      fifo_cnt;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  pop_fifo;
   resp_t                 head;

   assign offset   = tcdm_add - BASE_ADDR;
   assign in_range = (tcdm_add >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
   assign word_idx = offset[OFFS +: IDX_W];

`ifdef SFM_TCDM_RESP_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      lfsr <= SFM_TCDM_LFSR_SEED;
      else if (clear_i) lfsr <= SFM_TCDM_LFSR_SEED;
      else              lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall_ok = (lfsr[1:0] != 2'b00);
`else
   assign stall_ok = 1'b1;
`endif

   // Capping grants at OUTSTANDING bounds pipe plus FIFO occupancy, so the FIFO cannot overflow.
   assign tcdm_gnt = tcdm_req & enable_i & ~clear_i & (outstanding < CNT_W'(OUTSTANDING)) & stall_ok;

   always_ff @(posedge clk_i) begin
      if (tcdm_gnt && !tcdm_wen && in_range) begin
         for (int unsigned b = 0; b < BE_W; b++)
            if (tcdm_be[b]) mem[word_idx][b*8 +: 8] <= tcdm_data[b*8 +: 8];
      end
   end

   always_comb begin
      grant_resp.user = tcdm_user;
      grant_resp.data = '0;
      if (tcdm_wen) grant_resp.data = in_range ? mem[word_idx] : {DATA_WIDTH/32{SFM_TCDM_POISON}};
   end

   sfm_tcdm_resp_pipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (RESP_W)
   ) i_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .valid_i (tcdm_gnt),
      .data_i  (grant_resp),
      .valid_o (pipe_valid),
      .data_o  (pipe_data)
   );

   assign pipe_resp = pipe_data;

   // An empty FIFO passes the pipe exit straight through; it is only stored if not consumed.
   assign fifo_empty   = (fifo_cnt == '0);
   assign head         = fifo_empty ? pipe_resp : fifo_mem[rd_ptr];
   assign tcdm_r_valid = ~fifo_empty | pipe_valid;
   assign tcdm_r_data  = tcdm_r_valid ? head.data : '0;
   assign tcdm_r_user  = tcdm_r_valid & head.user;
   assign pop          = tcdm_r_valid & tcdm_r_ready;
   assign pop_fifo     = pop & ~fifo_empty;
   assign push         = pipe_valid & ~(fifo_empty & tcdm_r_ready);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (push && !clear_i) fifo_mem[wr_ptr] <= pipe_resp;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (clear_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)     wr_ptr <= ptr_inc(wr_ptr);
         if (pop_fifo) rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop_fifo);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= '0;
         err_q       <= 1'b0;
      end else if (clear_i) begin
         outstanding <= '0;
         err_q       <= 1'b0;
      end else begin
         outstanding <= outstanding + CNT_W'(tcdm_gnt) - CNT_W'(pop);
         if (tcdm_gnt && !in_range) err_q <= 1'b1;
      end
   end

   assign busy_o = (outstanding != '0);
   assign err_o  = err_q;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Bench for sfm_tcdm_responder: directed vector table, corner-case sequences and a random run against a queue model.
module tb_sfm_tcdm_responder;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic         clear = 1'b0;
   logic         enable = 1'b0;
   logic         req = 1'b0;
   logic         wen = 1'b0;
   logic         user = 1'b0;
   logic         r_ready = 1'b0;
   logic [31:0]  add = '0;
   logic [15:0]  be = '0;
   logic [127:0] wdata = '0;
   logic         gnt, r_valid, r_user, busy, err;
   logic [127:0] r_data;

   always #5 clk = ~clk;

   sfm_tcdm_responder #(
      .DATA_WIDTH   (128),
      .ADDR_WIDTH   (32),
      .MEM_DEPTH    (1024),
      .BASE_ADDR    (32'h0),
      .READ_LATENCY (2),
      .OUTSTANDING  (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .clear_i      (clear),
      .enable_i     (enable),
      .tcdm_req     (req),
      .tcdm_gnt     (gnt),
      .tcdm_add     (add),
      .tcdm_wen     (wen),
      .tcdm_be      (be),
      .tcdm_data    (wdata),
      .tcdm_user    (user),
      .tcdm_r_ready (r_ready),
      .tcdm_r_valid (r_valid),
      .tcdm_r_data  (r_data),
      .tcdm_r_user  (r_user),
      .busy_o       (busy),
      .err_o        (err)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [127:0] data;
      logic         user;
      bit           known;
      int           due;
   } exp_t;

   exp_t         q[$];
   logic [127:0] mem_m [int];
   bit           m_err = 1'b0;
   logic [15:0]  m_lfsr = 16'hACE1;
   int           cyc = 0;
   bit           last_gnt, last_rv, last_ruser;
   logic [127:0] last_rdata;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare outputs with the model at negedge, advance the model, return at posedge+1.
   task automatic step();
      bit           e_gnt, e_rv, stall_ok;
      exp_t         r;
      int           w;
      logic [127:0] m;
      @(negedge clk);
`ifdef SFM_TCDM_RESP_STALL_EN
      stall_ok = (m_lfsr[1:0] != 2'b00);
`else
      stall_ok = 1'b1;
`endif
      e_gnt = req && enable && !clear && (q.size() < 4) && stall_ok;
      e_rv  = (q.size() > 0) && (q[0].due <= cyc);
      check("gnt", gnt, e_gnt);
      check("r_valid", r_valid, e_rv);
      check("busy", busy, q.size() != 0);
      check("err", err, m_err);
      if (e_rv) begin
         check("r_user", r_user, q[0].user);
         if (q[0].known) check("r_data", r_data, q[0].data);
      end
      last_gnt = gnt; last_rv = r_valid; last_rdata = r_data; last_ruser = r_user;
      if (clear) begin
         q.delete();
         m_err  = 1'b0;
         m_lfsr = 16'hACE1;
      end else begin
         if (e_rv && r_ready) void'(q.pop_front());
         if (e_gnt) begin
            r.user = user; r.due = cyc + 2; r.known = 1'b1; r.data = '0;
            if (add >= 32'h4000) begin
               m_err = 1'b1;
               if (wen) r.data = {4{32'hDEADBEEF}};
            end else begin
               w = int'(add >> 4);
               if (wen) begin
                  if (mem_m.exists(w)) r.data = mem_m[w];
                  else r.known = 1'b0;
               end else if (mem_m.exists(w) || be == 16'hFFFF) begin
                  m = mem_m.exists(w) ? mem_m[w] : '0;
                  for (int b = 0; b < 16; b++) if (be[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
                  mem_m[w] = m;
               end
            end
            q.push_back(r);
         end
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit           wen;
      logic [31:0]  add;
      logic [15:0]  be;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      bit           exp_err;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int  gc, lat, cnt;
      bit  got;
      localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

      vecs[0] = '{1'b0, 32'h10,   16'hFFFF, D1,   128'h0,                 1'b0};
      vecs[1] = '{1'b1, 32'h10,   16'h0000, '0,   D1,                     1'b0};
      vecs[2] = '{1'b0, 32'h20,   16'hFFFF, '0,   128'h0,                 1'b0};
      vecs[3] = '{1'b0, 32'h20,   16'h000F, '1,   128'h0,                 1'b0};
      vecs[4] = '{1'b1, 32'h20,   16'hFFFF, '0,   128'hFFFFFFFF,          1'b0};
      vecs[5] = '{1'b1, 32'h2F,   16'h0000, '0,   128'hFFFFFFFF,          1'b0};
      vecs[6] = '{1'b0, 32'h4010, 16'hFFFF, '1,   128'h0,                 1'b1};
      vecs[7] = '{1'b1, 32'h4000, 16'h0000, '0,   {4{32'hDEADBEEF}},      1'b1};
      vecs[8] = '{1'b1, 32'h10,   16'h0000, '0,   D1,                     1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", gnt, 1'b0);
      check("rst_r_valid", r_valid, 1'b0);
      check("rst_r_data", r_data, '0);
      check("rst_r_user", r_user, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      @(posedge clk); #1;
      rst_ni = 1'b1; enable = 1'b1; r_ready = 1'b1;

      // Directed vectors: one transaction at a time, latency and payload against the table.
      foreach (vecs[i]) begin
         wen = vecs[i].wen; add = vecs[i].add; be = vecs[i].be; wdata = vecs[i].wdata;
         user = i[0]; req = 1'b1;
         got = 1'b0; gc = 0;
         for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (last_gnt) begin got = 1'b1; gc = cyc - 1; end
         end
         req = 1'b0;
         check($sformatf("vec%0d_granted", i), got, 1'b1);
         got = 1'b0; lat = -1;
         for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (last_rv) begin got = 1'b1; lat = cyc - 1 - gc; end
         end
         check($sformatf("vec%0d_responded", i), got, 1'b1);
         check($sformatf("vec%0d_latency", i), 128'(lat), 128'd2);
         check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_ruser", i), last_ruser, i[0]);
         check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      end
      repeat (3) step();
      check("err_sticky", err, 1'b1);
      clear = 1'b1; step(); clear = 1'b0;
      check("clear_err", err, 1'b0);
      check("clear_busy", busy, 1'b0);

      // Back-pressure: six reads with r_ready low, only four fit.
      wen = 1'b1; add = 32'h10; r_ready = 1'b0; req = 1'b1; cnt = 0;
      repeat (10) begin step(); cnt += int'(last_gnt); end
      check("bp_grants", 128'(cnt), 128'd4);
      check("bp_gnt_low", gnt, 1'b0);
      check("bp_busy", busy, 1'b1);
      r_ready = 1'b1;
      for (int t = 0; t < 20 && cnt < 6; t++) begin step(); cnt += int'(last_gnt); end
      req = 1'b0;
      check("bp_total", 128'(cnt), 128'd6);
      repeat (8) step();
      check("bp_drained", busy, 1'b0);

      // Clear with reads in flight.
      add = 32'h20; req = 1'b1; cnt = 0;
      for (int t = 0; t < 10 && cnt < 3; t++) begin step(); cnt += int'(last_gnt); end
      clear = 1'b1; step(); clear = 1'b0;
      check("clr_r_valid", r_valid, 1'b0);
      check("clr_busy", busy, 1'b0);
      step();
      check("clr_regrant", last_gnt, 1'b1);
      req = 1'b0; cnt = 0;
      repeat (6) begin step(); cnt += int'(last_rv); end
      check("clr_responses", 128'(cnt), 128'd1);

`ifdef SFM_TCDM_RESP_STALL_EN
      add = 32'h10; wen = 1'b1; req = 1'b1; cnt = 0;
      repeat (1000) begin step(); cnt += int'(last_gnt); end
      req = 1'b0;
      check("stall_ratio", (cnt >= 700 && cnt <= 800), 1'b1);
      repeat (8) step();
`endif

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         req     = ($urandom_range(0, 9) < 7);
         wen     = 1'($urandom_range(0, 1));
         add     = ($urandom_range(0, 19) == 0) ? (32'h4000 + 32'($urandom_range(0, 15)) * 16)
                                                : (32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 15)));
         be      = 16'($urandom);
         wdata   = {$urandom, $urandom, $urandom, $urandom};
         user    = 1'($urandom_range(0, 1));
         r_ready = ($urandom_range(0, 9) < 7);
         enable  = ($urandom_range(0, 9) < 9);
         clear   = ($urandom_range(0, 49) == 0);
         step();
      end
      clear = 1'b0; req = 1'b0; r_ready = 1'b1; enable = 1'b1;
      repeat (10) step();
      check("final_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
